// File: rtl/mem_pkg.sv
// Shared types for the main memory responder and the cache controller:
// FSM state encoding, transfer op encoding and default bus widths.
package mem_pkg;

  localparam int MEM_ADDR_W = 14;
  localparam int MEM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

// File: rtl/mem_array.sv
// Backing store for the main memory responder: 2**ADDR_W words,
// synchronous write with enable, combinational read, no reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/main_memory_responder.sv
// Fixed-latency main memory responder (IDLE -> WAIT -> DONE) for the cache.
// Optional read/write completion counters are enabled by MEM_PERF_CNT_EN.
module main_memory_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int RD_LAT = 4,
  parameter int WR_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              memrdy,
  output logic              busy
`ifdef MEM_PERF_CNT_EN
 ,output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
`endif
);

  localparam logic [3:0] RD_CNT0 = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_CNT0 = 4'(WR_LAT - 1);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] arr_rdata;
  logic              arr_we;
  logic              req_held;

  // Abort is judged against the request line of the op that was latched.
  assign req_held = (op_q == OP_WR) ? mem_we : mem_re;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (mem_re || mem_we) begin
          op_d    = mem_we ? OP_WR : OP_RD;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = mem_we ? WR_CNT0 : RD_CNT0;
          state_d = (cnt_d == 4'd0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (!req_held) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (op_q == OP_RD) rdata_d = arr_rdata;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_RD;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Request payload is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign arr_we = (state_q == DONE) && (op_q == OP_WR);
  assign memrdy = (state_q == DONE);
  assign busy   = (state_q != IDLE);
  assign rdata  = ((state_q == DONE) && (op_q == OP_RD)) ? arr_rdata : rdata_q;

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

`ifdef MEM_PERF_CNT_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else if (memrdy) begin
      if (op_q == OP_WR) wr_cnt_q <= wr_cnt_q + 32'd1;
      else               rd_cnt_q <= rd_cnt_q + 32'd1;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench for main_memory_responder: directed scenarios plus
// randomized reads/writes/aborts against a transaction-level memory model.
module tb_main_memory_responder;

  localparam int AW = 14;
  localparam int DW = 16;
  localparam int RL = 4;
  localparam int WL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_re = 1'b0;
  logic          mem_we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          memrdy;
  logic          busy;
`ifdef MEM_PERF_CNT_EN
  logic [31:0]   rd_count;
  logic [31:0]   wr_count;
`endif

  main_memory_responder #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .RD_LAT (RL),
    .WR_LAT (WL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .memrdy   (memrdy),
    .busy     (busy)
`ifdef MEM_PERF_CNT_EN
   ,.rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: word store, last read data, completion counts.
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] exp_rdata = '0;
  int            exp_rd = 0;
  int            exp_wr = 0;
  int            last_rdy_cyc = 0;
  logic [AW-1:0] wq [$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Idle cycles: nothing may complete, rdata must hold.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_memrdy", memrdy, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("idle_rdata", rdata, exp_rdata);
      @(posedge clk); #1;
    end
  endtask

  // One request starting just after a rising edge. hold = 0: hold until
  // memrdy; otherwise drop the request after 'hold' visible cycles.
  task automatic txn(input bit re, input bit we, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input int hold);
    int lat;
    bit abort;
    bit exp_busy;
    lat   = we ? WL : RL;
    abort = (hold != 0) && (hold < lat);
    mem_re = re; mem_we = we; addr = a; wdata = d;
    for (int k = 0; k <= lat + 1; k++) begin
      @(negedge clk);
      exp_busy = (k >= 1) && !(abort && k == hold + 1);
      chk("busy", busy, exp_busy);
      if (!abort && k == lat) begin
        if (we) begin
          ref_mem[int'(a)] = d;
          exp_wr++;
        end else begin
          exp_rdata = ref_mem[int'(a)];
          exp_rd++;
        end
        last_rdy_cyc = cyc;
      end
      chk("memrdy", memrdy, !abort && k == lat);
      chk("rdata", rdata, exp_rdata);
      if ((!abort && k == lat) || (abort && k == hold + 1)) break;
      if (abort && k == hold) begin
        mem_re = 1'b0; mem_we = 1'b0;
      end
      // Latched payload must be immune to later bus changes.
      if (k == 1) begin
        addr = ~a; wdata = ~d;
      end
    end
    @(posedge clk); #1;
    mem_re = 1'b0; mem_we = 1'b0;
  endtask

  initial begin
    int r1;
    int lat;
    int hold;
    bit we;
    bit re;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_memrdy", memrdy, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdata", rdata, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle(1);

    // Preload via writes, then plain read
    txn(0, 1, 14'h0123, 16'hBEEF, 0);
    txn(0, 1, 14'h1205, 16'h5A5A, 0);
    idle(1);
    txn(1, 0, 14'h0123, 16'h0000, 0);
    chk("read_beef", exp_rdata, 16'hBEEF);
    idle(2);

    // Evict then fill back to back
    txn(0, 1, 14'h3F05, 16'hA5A5, 0);
    r1 = last_rdy_cyc;
    txn(1, 0, 14'h1205, 16'h0000, 0);
    chk("evict_fill_gap", 32'(last_rdy_cyc - r1), 32'd5);
    txn(1, 0, 14'h3F05, 16'h0000, 0);

    // Simultaneous read+write: write wins, rdata untouched
    txn(1, 1, 14'h0010, 16'h1111, 0);
    txn(1, 0, 14'h0010, 16'h0000, 0);

    // Abort after 2 cycles, then an immediate new read
    txn(1, 0, 14'h0123, 16'h0000, 2);
    txn(1, 0, 14'h0123, 16'h0000, 0);

    // Address extremes do not alias
    txn(0, 1, 14'h0000, 16'h0001, 0);
    txn(0, 1, 14'h3FFF, 16'h0002, 0);
    txn(1, 0, 14'h0000, 16'h0000, 0);
    txn(1, 0, 14'h3FFF, 16'h0000, 0);
    idle(1);

    // Reset mid-write
    txn(0, 1, 14'h0042, 16'h1234, 0);
    idle(1);
    mem_we = 1'b1; addr = 14'h0042; wdata = 16'h7777;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_rdata = '0;
`ifdef MEM_PERF_CNT_EN
    exp_rd = 0; exp_wr = 0;
`endif
    #1;
    chk("rstmid_memrdy", memrdy, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_rdata", rdata, '0);
    @(negedge clk);
    chk("rstmid_memrdy2", memrdy, 1'b0);
    @(posedge clk); #1;
    mem_we = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle(2);
    txn(1, 0, 14'h0042, 16'h0000, 0);
    chk("rstmid_keep", exp_rdata, 16'h1234);

    // Randomized traffic
    wq.push_back(14'h0042);
    wq.push_back(14'h0123);
    for (int i = 0; i < 60; i++) begin
      we = ($urandom_range(0, 9) < 4);
      re = we ? ($urandom_range(0, 3) == 0) : 1'b1;
      if (we) a = AW'($urandom_range(0, (1 << AW) - 1));
      else    a = wq[$urandom_range(0, wq.size() - 1)];
      d = DW'($urandom);
      lat = we ? WL : RL;
      hold = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, lat - 1)) : 0;
      txn(re, we, a, d, hold);
      if (we && hold == 0) wq.push_back(a);
      if ($urandom_range(0, 2) == 0) idle(1);
    end

`ifdef MEM_PERF_CNT_EN
    chk("rd_count", rd_count, 32'(exp_rd));
    chk("wr_count", wr_count, 32'(exp_wr));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/main_memory_responder.md
MAIN_MEMORY_RESPONDER -- requirements
Module: main_memory_responder

Interface
REQ-001 Parameter ADDR_W, default 14: word address width, shared by I-side and D-side requests.
REQ-002 Parameter DATA_W, default 16: width of one transfer word.
REQ-003 Parameter RD_LAT, default 4: read latency in cycles, legal range 1..15.
REQ-004 Parameter WR_LAT, default 4: write latency in cycles, legal range 1..15.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 mem_re  input  1  read request, held high until memrdy is seen.
REQ-008 mem_we  input  1  write (evict) request, held high until memrdy is seen.
REQ-009 addr  input  ADDR_W  word address, stable while a request is held.
REQ-010 wdata  input  DATA_W  write data, stable while mem_we is held.
REQ-011 rdata  output  DATA_W  read data, valid in the memrdy cycle of a read.
REQ-012 memrdy  output  1  completion pulse.
REQ-013 busy  output  1  high in WAIT and DONE states.

Function
REQ-014 The block SHALL implement the FSM IDLE -> WAIT -> DONE -> IDLE.
REQ-015 In IDLE, mem_re or mem_we high at a rising edge SHALL latch the op, addr and wdata, load cnt = LAT-1, and enter WAIT (LAT-1 = 0 enters DONE directly).
REQ-016 In WAIT, cnt SHALL decrement each cycle; at cnt = 0 the FSM SHALL enter DONE.
REQ-017 memrdy SHALL be high for exactly one cycle, in DONE, LAT cycles after the first cycle the request was visible.
REQ-018 A read SHALL drive rdata = array[latched addr] during DONE; outside DONE, rdata SHALL hold its last value.
REQ-019 A write SHALL commit wdata to array[latched addr] on the edge that leaves DONE.
REQ-020 From DONE, the FSM SHALL return to IDLE unconditionally; a request held in the following cycle (for example, evict followed by fill, or data fill followed by instruction fill) SHALL be treated as new.
REQ-021 If mem_re and mem_we are both high in IDLE, the write SHALL win, using WR_LAT, and rdata SHALL be unchanged.
REQ-022 If the latched request input drops while in WAIT, the transaction SHALL abort: return to IDLE next edge, no write, no memrdy.
REQ-023 Changes to addr or wdata during WAIT SHALL be ignored because the values were latched in IDLE.
REQ-024 Array depth SHALL be 2**ADDR_W words, with no address wrap or aliasing.

Reset
REQ-025 Reset SHALL force the FSM to IDLE, cnt = 0, memrdy = 0, busy = 0, rdata = 0, and clear the latched op.
REQ-026 Reset SHALL NOT clear array contents.
REQ-027 Reset asserted mid-transaction SHALL drop the transaction with no write, and memrdy SHALL stay low.

Configuration
REQ-028 Macro MEM_PERF_CNT_EN, when defined, SHALL add the outputs rd_count[31:0] and wr_count[31:0], which increment on each completed read or write (memrdy cycle), reset to 0, and wrap at 2**32.
REQ-029 Aborted transactions SHALL NOT increment rd_count or wr_count.
REQ-030 Without MEM_PERF_CNT_EN, the rd_count and wr_count ports and their logic SHALL be absent, and behaviour SHALL be otherwise identical.

Structure
REQ-031 Package mem_pkg SHALL hold the FSM state encoding (IDLE, WAIT, DONE), the op encoding (OP_RD, OP_WR), and the default ADDR_W/DATA_W constants shared with the cache controller.
REQ-032 Sub-module mem_array SHALL hold the storage: synchronous write with enable, combinational read, parameterised by ADDR_W/DATA_W.
REQ-033 The FSM, counter and latch registers SHALL stay in main_memory_responder.

Verification
REQ-034 Read: preload array[0x0123] = 0xBEEF; hold mem_re with addr 0x0123 from cycle 0 -> memrdy high in cycle 4 only, rdata = 0xBEEF.
REQ-035 Evict then fill: mem_we with addr 0x3F05, wdata 0xA5A5, until memrdy; next cycle mem_re with addr 0x1205 -> two pulses 5 cycles apart; array[0x3F05] = 0xA5A5.
REQ-036 Simultaneous request: mem_re = mem_we = 1 with addr 0x0010, wdata 0x1111 -> write completes after WR_LAT; array[0x0010] = 0x1111; rdata unchanged.
REQ-037 Abort: mem_re high 2 cycles then low -> no memrdy; IDLE by cycle 3; a new read is accepted immediately after.
REQ-038 Reset mid-write: mem_we with addr 0x0042, wdata 0x7777; rst_n low in cycle 2 -> memrdy never asserts; array[0x0042] keeps its prior value; outputs are at reset values.
REQ-039 MEM_PERF_CNT_EN: 3 reads, 2 writes, 1 abort -> rd_count = 3, wr_count = 2.
